mips_regfile_write_arbiter: RTL and testbench

- Sequences and shares the single write port of the 8x32 MIPS register file between two requesters: A = datapath writeback, B = load/debug unit.
- After reset it runs an init sequence that zeroes registers 1..NUM_REGS-1, then arbitrates with round-robin.
- Its registered outputs drive write_reg, write_data and signal_reg_write directly. The register file commits on negedge clk, so values launched at posedge are stable at the commit edge.

---
 rtl/mips_regfile_pkg.sv | 11 +
 rtl/rr_arbiter_2.sv | 19 +
 rtl/mips_regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_mips_regfile_write_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   DATA_W / ADDR_W : default register-file geometry (8 x 32)
//   state_t         : arbiter sequencing state (init sweep vs. normal arbitration)
//   req_id_t        : identifies the two write requesters
package mips_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin arbiter.
//   i_elig_a/i_elig_b : requester is eligible this cycle
//   i_rr_last         : requester that won the most recent tie
//   o_grant_a/b       : one-hot (or zero) grant
module rr_arbiter_2
  import mips_regfile_pkg::*;
(
  input  logic    i_elig_a,
  input  logic    i_elig_b,
  input  req_id_t i_rr_last,
  output logic    o_grant_a,
  output logic    o_grant_b
);
  // On a tie the requester that did not win last time goes first.
  always_comb begin
    o_grant_a = i_elig_a && (!i_elig_b || (i_rr_last == REQ_B));
    o_grant_b = i_elig_b && (!i_elig_a || (i_rr_last == REQ_A));
  end
endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Owns the single write port of the MIPS register file. After reset it
// optionally sweeps registers 1..NUM_REGS-1 to zero, then shares the port
// between requester A (writeback) and requester B (load/debug) round-robin.
// All outputs are registered at posedge; the register file commits on the
// following negedge.
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_req_x, i_addr_x, i_data_x    : requester x write request (held until ack)
//   o_ack_x                        : one-cycle ack, write issued this cycle
//   o_write_reg/o_write_data       : register file write address / data
//   o_signal_reg_write             : register file write enable
//   o_init_busy                    : init sweep in progress
module mips_regfile_write_arbiter
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W     = mips_regfile_pkg::DATA_W,
  parameter int ADDR_W     = mips_regfile_pkg::ADDR_W,
  parameter int NUM_REGS   = 2 ** ADDR_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_data_a,
  output logic              o_ack_a,
  input  logic              i_req_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_ack_b,
  output logic [ADDR_W-1:0] o_write_reg,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_signal_reg_write,
  output logic              o_init_busy
);
  localparam state_t            ST_RESET = INIT_CLEAR ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

  state_t              r_state, w_state_nxt;
  req_id_t             r_rr_last, w_rr_last_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_write_reg, w_write_reg_nxt;
  logic [DATA_W-1:0]   r_write_data, w_write_data_nxt;
  logic                r_we, w_we_nxt;
  logic                r_ack_a, w_ack_a_nxt;
  logic                r_ack_b, w_ack_b_nxt;
  logic                r_init_busy, w_init_busy_nxt;

  logic w_elig_a, w_elig_b, w_grant_a, w_grant_b;

  // A requester just acked is still holding req at this edge; masking with
  // the current ack keeps it from being served twice for one request.
  assign w_elig_a = i_req_a & ~r_ack_a;
  assign w_elig_b = i_req_b & ~r_ack_b;

  rr_arbiter_2 u_rr (
    .i_elig_a  (w_elig_a),
    .i_elig_b  (w_elig_b),
    .i_rr_last (r_rr_last),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RESET;
      r_rr_last    <= REQ_B;
      r_cnt        <= ADDR_W'(1);
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_we         <= 1'b0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_init_busy  <= INIT_CLEAR;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_last    <= w_rr_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_write_reg  <= w_write_reg_nxt;
      r_write_data <= w_write_data_nxt;
      r_we         <= w_we_nxt;
      r_ack_a      <= w_ack_a_nxt;
      r_ack_b      <= w_ack_b_nxt;
      r_init_busy  <= w_init_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_last_nxt    = r_rr_last;
    w_cnt_nxt        = r_cnt;
    w_write_reg_nxt  = r_write_reg;
    w_write_data_nxt = r_write_data;
    w_we_nxt         = 1'b0;
    w_ack_a_nxt      = 1'b0;
    w_ack_b_nxt      = 1'b0;
    // Busy follows the state one edge late, so it covers the last init write.
    w_init_busy_nxt  = (r_state == ST_INIT);

    case (r_state)
      ST_INIT: begin
        w_write_reg_nxt  = r_cnt;
        w_write_data_nxt = '0;
        w_we_nxt         = 1'b1;
        w_cnt_nxt        = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_grant_a) begin
          w_write_reg_nxt  = i_addr_a;
          w_write_data_nxt = i_data_a;
          w_we_nxt         = (i_addr_a != '0);
          w_ack_a_nxt      = 1'b1;
        end else if (w_grant_b) begin
          w_write_reg_nxt  = i_addr_b;
          w_write_data_nxt = i_data_b;
          w_we_nxt         = (i_addr_b != '0);
          w_ack_b_nxt      = 1'b1;
        end
        // Priority only moves on a real tie.
        if (w_elig_a && w_elig_b) w_rr_last_nxt = w_grant_a ? REQ_A : REQ_B;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign o_ack_a            = r_ack_a;
  assign o_ack_b            = r_ack_b;
  assign o_write_reg        = r_write_reg;
  assign o_write_data       = r_write_data;
  assign o_signal_reg_write = r_we;
  assign o_init_busy        = r_init_busy;
endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
module tb_mips_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [2:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        o_ack_a, o_ack_b, o_we, o_busy;
  logic [2:0]  o_reg;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  mips_regfile_write_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_addr_a(addr_a), .i_data_a(data_a), .o_ack_a(o_ack_a),
    .i_req_b(req_b), .i_addr_b(addr_b), .i_data_b(data_b), .o_ack_b(o_ack_b),
    .o_write_reg(o_reg), .o_write_data(o_data),
    .o_signal_reg_write(o_we), .o_init_busy(o_busy)
  );

  // Register file model: commits on negedge, seeded with junk so the init
  // sweep is observable. r0 starts at 0 like the real file.
  logic [31:0] rf [8];
  logic        seed_rf;
  always @(negedge clk) begin
    if (seed_rf) begin
      for (int i = 0; i < 8; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hBAD0_0000 + i);
    end else if (o_we) begin
      rf[o_reg] <= o_data;
    end
  end

  typedef struct packed {
    logic        ack_a;
    logic        ack_b;
    logic        we;
    logic        busy;
    logic [2:0]  wreg;
    logic [31:0] wdata;
  } txn_t;

  txn_t q[$];
  int   passes = 0;
  int   checks = 0;
  logic pa = 1'b0, pb = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic a, input logic b, input logic we, input logic busy,
                      input logic [2:0] r, input logic [31:0] d);
    txn_t t;
    t.ack_a = a; t.ack_b = b; t.we = we; t.busy = busy; t.wreg = r; t.wdata = d;
    q.push_back(t);
  endtask

  // One clock: sample #1 after posedge, check invariants, pop scoreboard on output.
  task automatic tick();
    txn_t got, exp;
    @(posedge clk);
    #1;
    chk("ack_overlap", {63'd0, o_ack_a & o_ack_b}, 64'd0);
    chk("ack_b2b", {63'd0, (o_ack_a & pa) | (o_ack_b & pb)}, 64'd0);
    pa = o_ack_a;
    pb = o_ack_b;
    if (o_ack_a | o_ack_b | o_we) begin
      got = '{o_ack_a, o_ack_b, o_we, o_busy, o_reg, o_data};
      if (q.size() == 0) begin
        chk("unexpected_txn", 64'(got), 64'd0);
      end else begin
        exp = q.pop_front();
        chk("txn", 64'(got), 64'(exp));
      end
    end
  endtask

  task automatic init_seq();
    for (int i = 1; i < 8; i++) push(1'b0, 1'b0, 1'b1, 1'b1, 3'(i), 32'h0);
    repeat (7) tick();
    @(negedge clk);
    #1;
    for (int i = 1; i < 8; i++) chk("init_zero", 64'(rf[i]), 64'd0);
    chk("init_busy_last", {63'd0, o_busy}, 64'd1);
  endtask

  initial begin
    int ka, kb;
    seed_rf = 1'b1;
    rst_n = 1'b0;
    req_a = 1'b0; addr_a = 3'd0; data_a = 32'h0;
    req_b = 1'b0; addr_b = 3'd0; data_b = 32'h0;
    @(negedge clk);
    #1 seed_rf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", {o_ack_a, o_ack_b, o_we, o_busy, o_reg, o_data}, {4'b0001, 3'd0, 32'd0});

    // A waits through init with addr 5; first ack lands in cycle 8.
    req_a = 1'b1; addr_a = 3'd5; data_a = 32'h55;
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'h55);
    tick();
    req_a = 1'b0;
    tick();
    chk("idle_we", {63'd0, o_we}, 64'd0);
    chk("rf5", 64'(rf[5]), 64'h55);

    // Single requester, same-cycle ack.
    req_a = 1'b1; addr_a = 3'd3; data_a = 32'hDEADBEEF;
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'hDEADBEEF);
    tick();
    req_a = 1'b0;
    tick();
    chk("rf3", 64'(rf[3]), 64'hDEADBEEF);

    // Same target, tie with rr_last=B: A then B, B's value survives.
    req_a = 1'b1; addr_a = 3'd6; data_a = 32'd1;
    req_b = 1'b1; addr_b = 3'd6; data_b = 32'd2;
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 32'd1);
    push(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 32'd2);
    tick();
    req_a = 1'b0;
    tick();
    req_b = 1'b0;
    tick();
    chk("rf6", 64'(rf[6]), 64'd2);

    // Tie again: priority has flipped, B goes first.
    req_a = 1'b1; addr_a = 3'd7; data_a = 32'h71;
    req_b = 1'b1; addr_b = 3'd7; data_b = 32'h72;
    push(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 32'h72);
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'h71);
    tick();
    req_b = 1'b0;
    tick();
    req_a = 1'b0;
    tick();
    chk("rf7", 64'(rf[7]), 64'h71);

    // Both streaming: A,B,A,B,A,B.
    ka = 0; kb = 0;
    req_a = 1'b1; addr_a = 3'd2; data_a = 32'hA000;
    req_b = 1'b1; addr_b = 3'd4; data_b = 32'hB000;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'hA000 + k);
      push(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 32'hB000 + k);
    end
    repeat (6) begin
      tick();
      if (o_ack_a) begin
        ka++;
        if (ka < 3) data_a = 32'hA000 + ka; else req_a = 1'b0;
      end
      if (o_ack_b) begin
        kb++;
        if (kb < 3) data_b = 32'hB000 + kb; else req_b = 1'b0;
      end
    end
    chk("stream_cnt", {32'(ka), 32'(kb)}, {32'd3, 32'd3});
    tick();
    chk("rf2_rf4", {rf[2], rf[4]}, {32'hA002, 32'hB002});

    // Write to r0: acked but not enabled.
    req_b = 1'b1; addr_b = 3'd0; data_b = 32'h1234;
    push(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234);
    tick();
    req_b = 1'b0;
    tick();
    chk("rf0", 64'(rf[0]), 64'd0);

    // Reset lands between launch and commit: write must be suppressed.
    req_a = 1'b1; addr_a = 3'd5; data_a = 32'hCAFE;
    push(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'hCAFE);
    tick();
    req_a = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid", {o_ack_a, o_ack_b, o_we, o_busy}, 64'b0001);
    pa = 1'b0; pb = 1'b0;
    @(negedge clk);
    #1;
    chk("rf5_kept", 64'(rf[5]), 64'h55);
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
    tick();
    chk("busy_fall", {63'd0, o_busy}, 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
